// File: rtl/fir_decim_fifo.sv
// Post-filter stage: drops warm-up samples, decimates, rounds/saturates the Q15 result
// and buffers it in a first-word-fall-through FIFO with a valid/ready output.
module fir_decim_fifo #(
   parameter int IN_W   = 64,
   parameter int OUT_W  = 16,
   parameter int SHIFT  = 15,
   parameter int DECIM  = 4,
   parameter int WARMUP = 11,
   parameter int DEPTH  = 8
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          in_valid,
   input  logic signed [IN_W-1:0]        in_data,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic signed [OUT_W-1:0]       out_data,
   output logic                          out_sat,
   output logic [$clog2(DEPTH):0]        fifo_level,
   output logic                          overflow
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;
   localparam int WW = (WARMUP > 0) ? $clog2(WARMUP + 1) : 1;
   localparam int PW = (DECIM > 1) ? $clog2(DECIM) : 1;

   localparam logic signed [IN_W:0] HALF = (IN_W + 1)'(1) << (SHIFT - 1);
   localparam logic signed [IN_W:0] MAXV = ((IN_W + 1)'(1) << (OUT_W - 1)) - (IN_W + 1)'(1);
   localparam logic signed [IN_W:0] MINV = ~MAXV;

   logic [WW-1:0]          warmCnt;
   logic [PW-1:0]          phase;
   logic                   warmDone;
   logic                   candidate;
   logic                   keep;

   logic signed [IN_W:0]   sumExt;
   logic signed [IN_W:0]   rounded;
   logic                   satHi;
   logic                   satLo;
   logic [OUT_W-1:0]       rndData;

   logic                   s1Valid;
   logic [OUT_W-1:0]       s1Data;
   logic                   s1Sat;

   logic [OUT_W:0]         mem [DEPTH];
   logic [AW-1:0]          wrPtr;
   logic [AW-1:0]          rdPtr;
   logic [LW-1:0]          level;
   logic                   full;
   logic                   push;
   logic                   pop;
   logic [OUT_W:0]         head;

   assign warmDone  = (warmCnt == WW'(WARMUP));
   assign candidate = in_valid && warmDone;
   assign keep      = candidate && (phase == '0);

   // Warm-up counter saturates at WARMUP; the phase only moves on post-warm-up inputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         warmCnt <= '0;
         phase   <= '0;
      end else begin
         if (in_valid && !warmDone) begin
            warmCnt <= warmCnt + WW'(1);
         end
         if (candidate) begin
            phase <= (phase == PW'(DECIM - 1)) ? '0 : phase + PW'(1);
         end
      end
   end

   // One extra bit of headroom keeps the rounding offset from wrapping near full scale.
   always_comb begin
      sumExt  = $signed({in_data[IN_W-1], in_data}) + HALF;
      rounded = sumExt >>> SHIFT;
      satHi   = (rounded > MAXV);
      satLo   = (rounded < MINV);
      if (satHi) begin
         rndData = {1'b0, {(OUT_W-1){1'b1}}};
      end else if (satLo) begin
         rndData = {1'b1, {(OUT_W-1){1'b0}}};
      end else begin
         rndData = rounded[OUT_W-1:0];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         s1Valid <= 1'b0;
         s1Data  <= '0;
         s1Sat   <= 1'b0;
      end else begin
         s1Valid <= keep;
         if (keep) begin
            s1Data <= rndData;
            s1Sat  <= satHi || satLo;
         end
      end
   end

   assign full      = (level == LW'(DEPTH));
   assign pop       = out_valid && out_ready;
   assign push      = s1Valid && (!full || pop);

   // A full FIFO still accepts a write when the head leaves in the same cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         wrPtr    <= '0;
         rdPtr    <= '0;
         level    <= '0;
         overflow <= 1'b0;
      end else begin
         if (push) begin
            wrPtr <= wrPtr + AW'(1);
         end
         if (pop) begin
            rdPtr <= rdPtr + AW'(1);
         end
         case ({push, pop})
            2'b10:   level <= level + LW'(1);
            2'b01:   level <= level - LW'(1);
            default: level <= level;
         endcase
         if (s1Valid && full && !pop) begin
            overflow <= 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst && push) begin
         mem[wrPtr] <= {s1Sat, s1Data};
      end
   end

   // Storage is not reset, so the head is masked to zero whenever nothing is stored.
   assign head       = mem[rdPtr];
   assign out_valid  = (level != '0);
   assign out_data   = out_valid ? head[OUT_W-1:0] : '0;
   assign out_sat    = out_valid && head[OUT_W];
   assign fifo_level = level;

endmodule

// File: tb/tb_fir_decim_fifo.sv
// Bench for fir_decim_fifo: two instances (DECIM=1 and DECIM=4) share one stimulus stream
// and are compared every cycle against a queue-based model, plus literal scenario checks.
module tb_fir_decim_fifo;

   logic               clk = 1'b0;
   logic               rst = 1'b1;
   logic               in_valid = 1'b0;
   logic               out_ready = 1'b0;
   logic signed [63:0] in_data = '0;

   logic               ov1, ov4, os1, os4, of1, of4;
   logic signed [15:0] od1, od4;
   logic [3:0]         fl1, fl4;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   fir_decim_fifo #(.DECIM(1)) dut1 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
      .out_valid(ov1), .out_ready(out_ready), .out_data(od1), .out_sat(os1),
      .fifo_level(fl1), .overflow(of1)
   );

   fir_decim_fifo #(.DECIM(4)) dut4 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
      .out_valid(ov4), .out_ready(out_ready), .out_data(od4), .out_sat(os4),
      .fifo_level(fl4), .overflow(of4)
   );

   task automatic checkOutput(input string name, input logic signed [63:0] act,
                              input logic signed [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Expected {sat, value}: floor((x + 2^14) / 2^15) clipped to the 16-bit signed range.
   function automatic logic [16:0] expOut(input logic signed [63:0] x);
      logic signed [66:0] num;
      logic signed [66:0] q;
      num = x;
      num = num + 16384;
      q = num / 32768;
      if ((num % 32768) != 0 && num < 0) q = q - 1;
      if (q > 32767) return 17'h17fff;
      if (q < -32768) return 17'h18000;
      return {1'b0, q[15:0]};
   endfunction

   logic [16:0] mq1[$], mq4[$], got1[$], got4[$];
   int          cnt[2];
   bit          ifv[2];
   logic [16:0] ifd[2];
   bit          movf[2];
   bit          hv[2];
   logic [16:0] hd[2];

   function automatic int qSize(input int i);
      return (i == 0) ? mq1.size() : mq4.size();
   endfunction

   function automatic logic [16:0] qHead(input int i);
      return (i == 0) ? mq1[0] : mq4[0];
   endfunction

   function automatic void qPush(input int i, input logic [16:0] v);
      if (i == 0) mq1.push_back(v); else mq4.push_back(v);
   endfunction

   function automatic void qPop(input int i);
      if (i == 0) void'(mq1.pop_front()); else void'(mq4.pop_front());
   endfunction

   // Model: valid inputs are numbered from reset; number n is kept when n >= 11 and
   // (n-11) is a multiple of the decimation factor; it lands in the FIFO one edge later.
   always @(posedge clk) begin : modelProc
      bit mpop;
      bit kept;
      int dec;
      for (int i = 0; i < 2; i++) begin
         dec = (i == 0) ? 1 : 4;
         if (rst) begin
            cnt[i]  = 0;
            ifv[i]  = 0;
            movf[i] = 0;
            if (i == 0) mq1.delete(); else mq4.delete();
         end else begin
            if (hv[i] && out_ready) begin
               if (i == 0) got1.push_back(hd[0]); else got4.push_back(hd[1]);
            end
            mpop = (qSize(i) != 0) && out_ready;
            if (mpop) qPop(i);
            if (ifv[i]) begin
               if (qSize(i) < 8) qPush(i, ifd[i]);
               else movf[i] = 1;
            end
            kept   = in_valid && (cnt[i] >= 11) && (((cnt[i] - 11) % dec) == 0);
            ifv[i] = kept;
            ifd[i] = expOut(in_data);
            if (in_valid) cnt[i]++;
         end
      end
   end

   // Per-cycle comparison of both instances against the model, away from the active edge.
   always @(negedge clk) begin
      hv[0] = ov1;
      hd[0] = {os1, od1};
      hv[1] = ov4;
      hd[1] = {os4, od4};
      checkOutput("d1_valid", ov1, qSize(0) != 0);
      checkOutput("d1_level", fl1, qSize(0));
      checkOutput("d1_overflow", of1, movf[0]);
      if (qSize(0) != 0) checkOutput("d1_head", {os1, od1}, qHead(0));
      checkOutput("d4_valid", ov4, qSize(1) != 0);
      checkOutput("d4_level", fl4, qSize(1));
      checkOutput("d4_overflow", of4, movf[1]);
      if (qSize(1) != 0) checkOutput("d4_head", {os4, od4}, qHead(1));
   end

   task automatic applyStimulus(input bit r, input bit v, input logic signed [63:0] d,
                                input bit rdy);
      @(negedge clk);
      rst       = r;
      in_valid  = v;
      in_data   = d;
      out_ready = rdy;
   endtask

   task automatic doReset();
      applyStimulus(1'b1, 1'b0, '0, 1'b0);
      applyStimulus(1'b0, 1'b0, '0, 1'b0);
   endtask

   task automatic checkStream(input string name, input logic [16:0] got[$],
                              input logic [16:0] exp[$]);
      checkOutput({name, "_count"}, got.size(), exp.size());
      for (int k = 0; k < exp.size() && k < got.size(); k++)
         checkOutput($sformatf("%s_%0d", name, k), got[k], exp[k]);
   endtask

   // Ramp (n+1)<<15 straight after reset: nothing appears until sample 11 (value 12)
   // has passed the round stage and the FIFO write.
   task automatic warmupRun(input string tag);
      for (int n = 0; n < 16; n++) begin
         applyStimulus(1'b0, 1'b1, 64'(n + 1) <<< 15, 1'b1);
         checkOutput({tag, "_valid"}, ov1, n >= 13);
         if (n >= 13) checkOutput({tag, "_data"}, od1, n - 1);
      end
      repeat (4) applyStimulus(1'b0, 1'b0, '0, 1'b1);
   endtask

   logic signed [63:0] roundIn[9];
   logic [16:0]        expQ[$];
   logic signed [63:0] rd;
   int                 rk;
   bit                 rr;

   initial begin
      roundIn = '{64'sd49152, -64'sd49152, 64'sd16384, -64'sd16384, -64'sd16385,
                  64'sd1073709056, 64'sd1099511627776, -64'sd1099511627776,
                  64'h7fffffffffffffff};

      checkOutput("model_pin_pos", expOut(64'sd49152), 17'h00002);
      checkOutput("model_pin_neg", expOut(-64'sd49152), 17'h0ffff);
      checkOutput("model_pin_max", expOut(64'h7fffffffffffffff), 17'h17fff);

      doReset();
      checkOutput("reset_valid", ov1, 0);
      checkOutput("reset_data", od1, 0);
      checkOutput("reset_level", fl1, 0);
      warmupRun("warm");

      got1.delete();
      for (int k = 0; k < 9; k++) applyStimulus(1'b0, 1'b1, roundIn[k], 1'b1);
      repeat (4) applyStimulus(1'b0, 1'b0, '0, 1'b1);
      expQ = '{17'h00002, 17'h0ffff, 17'h00001, 17'h00000, 17'h0ffff, 17'h07fff,
               17'h17fff, 17'h18000, 17'h17fff};
      checkStream("round", got1, expQ);

      doReset();
      got4.delete();
      for (int k = 0; k < 11; k++) applyStimulus(1'b0, 1'b1, 64'($urandom), 1'b1);
      for (int k = 0; k < 16; k++) begin
         applyStimulus(1'b0, 1'b1, 64'(k) <<< 15, 1'b1);
         applyStimulus(1'b0, 1'b0, 64'($urandom), 1'b1);
      end
      repeat (4) applyStimulus(1'b0, 1'b0, '0, 1'b1);
      expQ = '{17'd0, 17'd4, 17'd8, 17'd12};
      checkStream("decim", got4, expQ);

      doReset();
      for (int k = 0; k < 11; k++) applyStimulus(1'b0, 1'b1, '0, 1'b0);
      for (int k = 1; k <= 9; k++) applyStimulus(1'b0, 1'b1, 64'(k) <<< 15, 1'b0);
      repeat (2) applyStimulus(1'b0, 1'b0, '0, 1'b0);
      checkOutput("ovf_level", fl1, 8);
      checkOutput("ovf_flag", of1, 1);
      got1.delete();
      repeat (10) applyStimulus(1'b0, 1'b0, '0, 1'b1);
      expQ = '{17'd1, 17'd2, 17'd3, 17'd4, 17'd5, 17'd6, 17'd7, 17'd8};
      checkStream("drain", got1, expQ);
      checkOutput("ovf_sticky", of1, 1);

      for (int k = 21; k <= 28; k++) applyStimulus(1'b0, 1'b1, 64'(k) <<< 15, 1'b0);
      repeat (2) applyStimulus(1'b0, 1'b0, '0, 1'b0);
      checkOutput("refill_level", fl1, 8);
      got1.delete();
      applyStimulus(1'b0, 1'b1, 64'(29) <<< 15, 1'b0);
      applyStimulus(1'b0, 1'b0, '0, 1'b1);
      applyStimulus(1'b0, 1'b0, '0, 1'b1);
      checkOutput("pushpop_level", fl1, 8);
      repeat (10) applyStimulus(1'b0, 1'b0, '0, 1'b1);
      expQ = '{17'd21, 17'd22, 17'd23, 17'd24, 17'd25, 17'd26, 17'd27, 17'd28, 17'd29};
      checkStream("pushpop", got1, expQ);

      for (int k = 41; k <= 45; k++) applyStimulus(1'b0, 1'b1, 64'(k) <<< 15, 1'b0);
      repeat (2) applyStimulus(1'b0, 1'b0, '0, 1'b0);
      checkOutput("mid_level", fl1, 5);
      doReset();
      checkOutput("mid_rst_valid", ov1, 0);
      checkOutput("mid_rst_level", fl1, 0);
      checkOutput("mid_rst_ovf", of1, 0);
      checkOutput("mid_rst_ovf4", of4, 0);
      warmupRun("rewarm");

      for (int c = 0; c < 3000; c++) begin
         case ($urandom_range(0, 3))
            0: rd = longint'($signed($urandom));
            1: rd = {$urandom, $urandom};
            2: begin
               rk = int'($urandom_range(0, 80000)) - 40000;
               rd = longint'(rk) * 32768 + 16384 + longint'($urandom_range(0, 2)) - 1;
            end
            default: rd = longint'($signed($urandom)) >>> 8;
         endcase
         case ((c / 500) % 3)
            0: rr = ($urandom_range(0, 9) != 0);
            1: rr = ($urandom_range(0, 9) < 3);
            default: rr = ($urandom_range(0, 9) < 7);
         endcase
         applyStimulus($urandom_range(0, 599) == 0, $urandom_range(0, 3) != 0, rd, rr);
      end
      repeat (3) applyStimulus(1'b0, 1'b0, '0, 1'b1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/fir_decim_fifo.md
Name: fir_decim_fifo

Overview:
Downstream stage of the 9-tap symmetric FIR filter tree. Consumes the filter's 64-bit signed output stream and discards samples produced while the delay line is filling. Decimates by DECIM, rounds and saturates the Q15-scaled result to 16 bits, and buffers it in a small FIFO with a valid/ready output handshake for the next processing stage.

Parameters:
IN_W, 64, width of signed filter output accepted on in_data
OUT_W, 16, width of signed output sample
SHIFT, 15, right shift applied with rounding (Q15 coefficient scaling)
DECIM, 4, keep 1 of every DECIM post-warm-up samples (DECIM >= 1)
WARMUP, 11, number of leading valid inputs discarded after reset (8 delay taps + 3 pipeline registers)
DEPTH, 8, FIFO entries (power of two, >= 2)

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous, active-high reset
in_valid  in  1  in_data carries a filter output this cycle
in_data  in  IN_W  signed filter output
out_valid  out  1  FIFO head valid
out_ready  in  1  consumer accepts head this cycle
out_data  out  OUT_W  signed rounded/saturated sample at FIFO head
out_sat  out  1  head sample was clipped
fifo_level  out  $clog2(DEPTH)+1  entries currently stored
overflow  out  1  sticky: a kept sample was dropped because the FIFO was full

Behaviour:
- Reset (sampled at rising edge with rst=1): warm-up counter=0, decimation phase=0, stage-1 valid=0, FIFO pointers=0. Outputs: out_valid=0, out_data=0, out_sat=0, fifo_level=0, overflow=0. A reset mid-stream flushes the pipeline and FIFO and restarts warm-up. It takes priority over every other event in the same cycle.
- Warm-up: the counter increments on each in_valid until it reaches WARMUP, then saturates. Inputs with in_valid=1 while counter<WARMUP are discarded. The (WARMUP+1)th valid input is the first candidate.
- Decimation: among candidates, the phase counter runs 0..DECIM-1 and wraps. A candidate is kept when phase==0. The phase advances on every candidate, whether kept or not. With DECIM=1, every candidate is kept.
- Round/saturate (stage 1, registered):
  - Compute t = (in_data + 2^(SHIFT-1)) >>> SHIFT at IN_W+1 bits, so the addition cannot wrap. This rounds half toward +infinity.
  - If t > 2^(OUT_W-1)-1: result = 32767, sat=1.
  - If t < -2^(OUT_W-1): result = -32768, sat=1.
  - Otherwise: result = t[OUT_W-1:0], sat=0.
  - Stage-1 valid is set for a kept sample and cleared otherwise.
- FIFO write: at the edge after stage 1 is loaded, with stage-1 valid=1.
  - Not full: write {sat, result}.
  - Full with a pop in the same cycle: the write still succeeds and the level is unchanged.
  - Full with no pop: drop the sample and set overflow=1. Overflow clears only on reset.
- Latency: a kept input sampled at edge k reaches the FIFO at edge k+1. out_valid rises after edge k+1 if the FIFO was empty. There is no bypass: an empty FIFO never presents same-cycle data.
- Output handshake: first-word-fall-through.
  - out_valid = (level != 0). out_data and out_sat always reflect the head entry.
  - A pop occurs when out_valid & out_ready. Head data stays stable while out_valid=1 and out_ready=0.
  - out_ready while empty has no effect.
- Pointers: log2(DEPTH) bits, wrap modulo DEPTH. Level is updated as +1 (push only), -1 (pop only), or unchanged (both or neither).
- in_valid=0 cycles advance neither counter.

Test Plan:
- Warm-up: reset, then in_valid=1 every cycle with in_data=(n+1)<<15 for n=0.., DECIM=1, out_ready=1. First output is out_data=12 (sample n=11), 2 cycles after that sample. No output appears earlier.
- Rounding, DECIM=1, post-warm-up. Required results with out_sat=0:
  - 49152 -> 2
  - -49152 -> -1
  - 16384 -> 1
  - -16384 -> 0
  - -16385 -> -1
  - 32767*32768 -> 32767
- Saturation:
  - 2^40 -> 32767, out_sat=1
  - -2^40 -> -32768, out_sat=1
  - 2^63-1 -> 32767, out_sat=1 (no wrap)
- Decimation DECIM=4: post-warm-up ramp 0,1,2,...<<15 with in_valid toggling 1/0. Outputs are 0,4,8,12, unaffected by idle cycles.
- Backpressure/overflow:
  - DECIM=1, out_ready=0, 9 kept samples 1..9. fifo_level=8, overflow=1, sample 9 lost.
  - Then out_ready=1: outputs 1..8 in order, one per cycle. overflow stays 1.
  - Full FIFO with simultaneous push and pop: no loss, level stays 8.
- Reset mid-stream: with level=5, assert rst for 1 cycle. Next cycle out_valid=0, level=0, overflow=0. The warm-up discard of 11 samples repeats.
